motion_alarm_ctrl: RTL and testbench

- Frame-level controller that sequences the motion detection datapath.
- Enables the detector, skips warm-up frames and calibrates a per-frame changed-pixel limit from scene noise.
- Then monitors per-frame change counts and drives a debounced, held, acknowledged motion alarm.
- Sits between the per-pixel change counter (which supplies one count per frame) and the system alarm/indicator logic.

---
 rtl/motion_alarm_ctrl_if.sv | 33 +++
 rtl/motion_alarm_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_motion_alarm_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/motion_alarm_ctrl_if.sv
// motion_alarm_ctrl_if
// Groups the frame-level signals exchanged between the motion alarm
// controller and its surroundings.
//   master modport (system side / bench):
//     drives enable, frame_done, frame_change_count and ack
//     samples det_enable, pixel_limit, calib_done, motion_alarm,
//     alarm_frames and state
//   slave modport (controller side): the mirror image of master
// clk and rst_n are not part of the interface; they stay plain ports.
interface motion_alarm_ctrl_if;
    logic        enable;
    logic        frame_done;
    logic [17:0] frame_change_count;
    logic        ack;
    logic        det_enable;
    logic [17:0] pixel_limit;
    logic        calib_done;
    logic        motion_alarm;
    logic [7:0]  alarm_frames;
    logic [2:0]  state;

    modport master (
        output enable, frame_done, frame_change_count, ack,
        input  det_enable, pixel_limit, calib_done, motion_alarm,
               alarm_frames, state
    );

    modport slave (
        input  enable, frame_done, frame_change_count, ack,
        output det_enable, pixel_limit, calib_done, motion_alarm,
               alarm_frames, state
    );
endinterface

// File: rtl/motion_alarm_ctrl.sv
// motion_alarm_ctrl
// Frame-level sequencer for the motion detection datapath. After enable it
// skips a number of warm-up frames, averages 2^CALIB_LOG2 frames of change
// counts to derive a clamped per-frame pixel limit, then watches each
// frame's change count and raises a debounced alarm. The alarm is held for
// at least HOLD_FRAMES quiet frames and only drops once it is acknowledged.
// Ports:
//   clk    rising-edge system clock
//   rst_n  asynchronous active-low reset
//   bus    motion_alarm_ctrl_if.slave (frame inputs, ack, status outputs)
module motion_alarm_ctrl #(
    parameter int unsigned WARMUP_FRAMES = 4,
    parameter int unsigned CALIB_LOG2    = 3,
    parameter logic [17:0] MARGIN        = 18'd20000,
    parameter logic [17:0] LIMIT_MIN     = 18'd1000,
    parameter logic [17:0] LIMIT_MAX     = 18'd250000,
    parameter int unsigned CONSECUTIVE   = 3,
    parameter int unsigned HOLD_FRAMES   = 30
) (
    input logic               clk,
    input logic               rst_n,
    motion_alarm_ctrl_if.slave bus
);

    localparam int ACC_W  = 18 + CALIB_LOG2;
    localparam int WARM_W = $clog2(WARMUP_FRAMES + 1);
    localparam int CAL_W  = CALIB_LOG2 + 1;
    localparam int CONS_W = $clog2(CONSECUTIVE + 1);
    localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_FRAMES - 1);
    localparam logic [CAL_W-1:0]  CAL_LAST  = CAL_W'((1 << CALIB_LOG2) - 1);
    localparam logic [CONS_W-1:0] CONS_MAX  = CONS_W'(CONSECUTIVE);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_FRAMES);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WARMUP = 3'd1,
        CALIB  = 3'd2,
        ARMED  = 3'd3,
        ALARM  = 3'd4
    } state_t;

    state_t            state_q;
    logic              det_enable_q;
    logic [17:0]       pixel_limit_q;
    logic              calib_done_q;
    logic              motion_alarm_q;
    logic [7:0]        alarm_frames_q;
    logic [WARM_W-1:0] warm_cnt_q;
    logic [CAL_W-1:0]  cal_cnt_q;
    logic [ACC_W-1:0]  acc_q;
    logic [CONS_W-1:0] consec_q;
    logic [HOLD_W-1:0] hold_q;
    logic              ack_latched_q;

    logic [ACC_W-1:0]  acc_d;
    logic [17:0]       mean;
    logic [18:0]       limit_sum;
    logic [17:0]       limit_d;
    logic              over_limit;
    logic [CONS_W-1:0] consec_d;
    logic [HOLD_W-1:0] hold_d;
    logic [7:0]        alarm_frames_d;
    logic              ack_seen;

    // Calibration: the accumulator is wide enough for 2^CALIB_LOG2 full-scale
    // counts, and the mean plus margin is formed at 19 bits so the clamp
    // sees the true value rather than a wrapped one.
    always_comb begin
        acc_d     = acc_q + ACC_W'(bus.frame_change_count);
        mean      = acc_d[ACC_W-1:CALIB_LOG2];
        limit_sum = {1'b0, mean} + {1'b0, MARGIN};
        if (limit_sum > {1'b0, LIMIT_MAX}) begin
            limit_d = LIMIT_MAX;
        end else if (limit_sum < {1'b0, LIMIT_MIN}) begin
            limit_d = LIMIT_MIN;
        end else begin
            limit_d = limit_sum[17:0];
        end
    end

    // Per-frame detection helpers; a count equal to the limit is over-limit.
    always_comb begin
        over_limit     = (bus.frame_change_count >= pixel_limit_q);
        consec_d       = '0;
        hold_d         = '0;
        if (over_limit) begin
            consec_d = (consec_q == CONS_MAX) ? consec_q : consec_q + CONS_W'(1);
        end else begin
            hold_d   = (hold_q == HOLD_MAX) ? hold_q : hold_q + HOLD_W'(1);
        end
        alarm_frames_d = (alarm_frames_q == 8'hFF) ? alarm_frames_q : alarm_frames_q + 8'd1;
        ack_seen       = ack_latched_q | bus.ack;
    end

    // Main FSM. enable low wins over everything except reset and returns to
    // IDLE while keeping the last calibrated pixel limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            det_enable_q   <= 1'b0;
            pixel_limit_q  <= LIMIT_MAX;
            calib_done_q   <= 1'b0;
            motion_alarm_q <= 1'b0;
            alarm_frames_q <= '0;
            warm_cnt_q     <= '0;
            cal_cnt_q      <= '0;
            acc_q          <= '0;
            consec_q       <= '0;
            hold_q         <= '0;
            ack_latched_q  <= 1'b0;
        end else if (!bus.enable) begin
            state_q        <= IDLE;
            det_enable_q   <= 1'b0;
            calib_done_q   <= 1'b0;
            motion_alarm_q <= 1'b0;
            alarm_frames_q <= '0;
            warm_cnt_q     <= '0;
            cal_cnt_q      <= '0;
            acc_q          <= '0;
            consec_q       <= '0;
            hold_q         <= '0;
            ack_latched_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q      <= WARMUP;
                    det_enable_q <= 1'b1;
                    warm_cnt_q   <= '0;
                end
                WARMUP: begin
                    if (bus.frame_done) begin
                        if (warm_cnt_q == WARM_LAST) begin
                            state_q    <= CALIB;
                            warm_cnt_q <= '0;
                            cal_cnt_q  <= '0;
                            acc_q      <= '0;
                        end else begin
                            warm_cnt_q <= warm_cnt_q + WARM_W'(1);
                        end
                    end
                end
                CALIB: begin
                    if (bus.frame_done) begin
                        acc_q <= acc_d;
                        if (cal_cnt_q == CAL_LAST) begin
                            pixel_limit_q <= limit_d;
                            calib_done_q  <= 1'b1;
                            consec_q      <= '0;
                            state_q       <= ARMED;
                        end else begin
                            cal_cnt_q <= cal_cnt_q + CAL_W'(1);
                        end
                    end
                end
                ARMED: begin
                    if (bus.frame_done) begin
                        consec_q <= consec_d;
                        if (consec_d == CONS_MAX) begin
                            state_q        <= ALARM;
                            motion_alarm_q <= 1'b1;
                            alarm_frames_q <= '0;
                            hold_q         <= '0;
                            ack_latched_q  <= 1'b0;
                        end
                    end
                end
                ALARM: begin
                    ack_latched_q <= ack_seen;
                    if (bus.frame_done) begin
                        alarm_frames_q <= alarm_frames_d;
                        hold_q         <= hold_d;
                        if (hold_d == HOLD_MAX && ack_seen) begin
                            state_q        <= ARMED;
                            motion_alarm_q <= 1'b0;
                            consec_q       <= '0;
                            ack_latched_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.det_enable   = det_enable_q;
    assign bus.pixel_limit  = pixel_limit_q;
    assign bus.calib_done   = calib_done_q;
    assign bus.motion_alarm = motion_alarm_q;
    assign bus.alarm_frames = alarm_frames_q;
    assign bus.state        = state_q;

endmodule

// File: tb/tb_motion_alarm_ctrl.sv
// tb_motion_alarm_ctrl
// Directed bench for motion_alarm_ctrl: one instance with default parameters
// and a second with MARGIN=0 for the lower-clamp case. Inputs change on the
// falling edge and outputs are sampled there too.
module tb_motion_alarm_ctrl;

    logic clk = 1'b0;
    logic rst_n;

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    motion_alarm_ctrl_if ifc ();
    motion_alarm_ctrl_if ifc2 ();

    motion_alarm_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    motion_alarm_ctrl #(.MARGIN(18'd0)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc2)
    );

    int checks = 0;
    int errors = 0;

    // One comparison: counts it and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // One frame_done pulse carrying count, optionally with a coincident ack.
    // Both instances see the same frame traffic; only enable differs.
    task automatic applyStimulus(input logic [17:0] count, input logic ackIn = 1'b0);
        @(negedge clk);
        ifc.frame_done          = 1'b1;
        ifc.frame_change_count  = count;
        ifc.ack                 = ackIn;
        ifc2.frame_done         = 1'b1;
        ifc2.frame_change_count = count;
        @(negedge clk);
        ifc.frame_done  = 1'b0;
        ifc.ack         = 1'b0;
        ifc2.frame_done = 1'b0;
    endtask

    task automatic runFrames(input int n, input logic [17:0] count);
        for (int i = 0; i < n; i++) applyStimulus(count);
    endtask

    task automatic pulseAck();
        @(negedge clk);
        ifc.ack = 1'b1;
        @(negedge clk);
        ifc.ack = 1'b0;
    endtask

    // Directed sequence covering calibration, alarm entry/exit and overrides.
    initial begin
        rst_n = 1'b0;
        ifc.enable = 1'b0; ifc.frame_done = 1'b0; ifc.frame_change_count = '0; ifc.ack = 1'b0;
        ifc2.enable = 1'b0; ifc2.frame_done = 1'b0; ifc2.frame_change_count = '0; ifc2.ack = 1'b0;
        #23;
        checkOutput("rst_state", 32'(ifc.state), 0);
        checkOutput("rst_limit", 32'(ifc.pixel_limit), 250000);
        checkOutput("rst_det", 32'(ifc.det_enable), 0);
        checkOutput("rst_calib", 32'(ifc.calib_done), 0);
        checkOutput("rst_alarm", 32'(ifc.motion_alarm), 0);
        checkOutput("rst_frames", 32'(ifc.alarm_frames), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // enable rises together with a frame_done that must be ignored
        @(negedge clk);
        ifc.enable = 1'b1;
        ifc.frame_done = 1'b1;
        ifc.frame_change_count = 18'd10000;
        @(negedge clk);
        ifc.frame_done = 1'b0;
        checkOutput("en_state", 32'(ifc.state), 1);
        checkOutput("en_det", 32'(ifc.det_enable), 1);
        runFrames(3, 18'd10000);
        checkOutput("warm3_state", 32'(ifc.state), 1);
        applyStimulus(18'd10000);
        checkOutput("warm4_state", 32'(ifc.state), 2);
        runFrames(7, 18'd10000);
        checkOutput("cal7_state", 32'(ifc.state), 2);
        checkOutput("cal7_done", 32'(ifc.calib_done), 0);
        applyStimulus(18'd10000);
        checkOutput("cal_limit", 32'(ifc.pixel_limit), 30000);
        checkOutput("cal_done", 32'(ifc.calib_done), 1);
        checkOutput("cal_state", 32'(ifc.state), 3);

        // debounce: the 29999 frame breaks the run; equal-to-limit is over
        applyStimulus(18'd30000);
        applyStimulus(18'd30000);
        applyStimulus(18'd29999);
        checkOutput("deb3_alarm", 32'(ifc.motion_alarm), 0);
        applyStimulus(18'd30000);
        applyStimulus(18'd30000);
        checkOutput("deb5_alarm", 32'(ifc.motion_alarm), 0);
        applyStimulus(18'd30000);
        checkOutput("deb6_alarm", 32'(ifc.motion_alarm), 1);
        checkOutput("deb6_state", 32'(ifc.state), 4);
        checkOutput("deb6_frames", 32'(ifc.alarm_frames), 0);

        // early ack, retrigger at hold=20, exit after 30 further quiet frames
        runFrames(2, 18'd10000);
        pulseAck();
        runFrames(18, 18'd10000);
        checkOutput("hold20_alarm", 32'(ifc.motion_alarm), 1);
        checkOutput("hold20_frames", 32'(ifc.alarm_frames), 20);
        applyStimulus(18'd40000);
        runFrames(29, 18'd10000);
        checkOutput("retrig29_alarm", 32'(ifc.motion_alarm), 1);
        checkOutput("retrig29_frames", 32'(ifc.alarm_frames), 50);
        applyStimulus(18'd10000);
        checkOutput("exit_alarm", 32'(ifc.motion_alarm), 0);
        checkOutput("exit_state", 32'(ifc.state), 3);
        checkOutput("exit_frames", 32'(ifc.alarm_frames), 51);

        // ack while ARMED is ignored; without ack the alarm persists
        pulseAck();
        runFrames(3, 18'd40000);
        checkOutput("a2_alarm", 32'(ifc.motion_alarm), 1);
        checkOutput("a2_frames", 32'(ifc.alarm_frames), 0);
        runFrames(100, 18'd10000);
        checkOutput("a2_100_alarm", 32'(ifc.motion_alarm), 1);
        checkOutput("a2_100_frames", 32'(ifc.alarm_frames), 100);
        runFrames(155, 18'd10000);
        checkOutput("a2_255_frames", 32'(ifc.alarm_frames), 255);
        applyStimulus(18'd10000);
        checkOutput("a2_sat_frames", 32'(ifc.alarm_frames), 255);
        checkOutput("a2_sat_alarm", 32'(ifc.motion_alarm), 1);
        applyStimulus(18'd10000, 1'b1);
        checkOutput("a2_ack_alarm", 32'(ifc.motion_alarm), 0);
        checkOutput("a2_ack_state", 32'(ifc.state), 3);
        checkOutput("a2_ack_frames", 32'(ifc.alarm_frames), 255);

        // enable drop during ALARM with a coincident frame_done
        runFrames(3, 18'd40000);
        checkOutput("a3_state", 32'(ifc.state), 4);
        @(negedge clk);
        ifc.enable = 1'b0;
        ifc.frame_done = 1'b1;
        ifc.frame_change_count = 18'd40000;
        @(negedge clk);
        ifc.frame_done = 1'b0;
        checkOutput("dis_state", 32'(ifc.state), 0);
        checkOutput("dis_alarm", 32'(ifc.motion_alarm), 0);
        checkOutput("dis_limit", 32'(ifc.pixel_limit), 30000);
        checkOutput("dis_det", 32'(ifc.det_enable), 0);
        checkOutput("dis_calib", 32'(ifc.calib_done), 0);
        checkOutput("dis_frames", 32'(ifc.alarm_frames), 0);

        // reset in the middle of calibration
        @(negedge clk);
        ifc.enable = 1'b1;
        @(negedge clk);
        runFrames(7, 18'd10000);
        checkOutput("midcal_state", 32'(ifc.state), 2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_state", 32'(ifc.state), 0);
        checkOutput("midrst_limit", 32'(ifc.pixel_limit), 250000);
        checkOutput("midrst_det", 32'(ifc.det_enable), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // upper clamp: 240000 + 20000 exceeds LIMIT_MAX
        @(negedge clk);
        runFrames(12, 18'd240000);
        checkOutput("hiclamp_limit", 32'(ifc.pixel_limit), 250000);
        checkOutput("hiclamp_state", 32'(ifc.state), 3);

        // full-scale counts must not wrap the accumulator
        @(negedge clk);
        ifc.enable = 1'b0;
        @(negedge clk);
        ifc.enable = 1'b1;
        @(negedge clk);
        runFrames(12, 18'h3FFFF);
        checkOutput("full_limit", 32'(ifc.pixel_limit), 250000);

        // lower clamp on the MARGIN=0 instance
        @(negedge clk);
        ifc.enable = 1'b0;
        ifc2.enable = 1'b1;
        @(negedge clk);
        runFrames(12, 18'd500);
        checkOutput("loclamp_limit", 32'(ifc2.pixel_limit), 1000);
        checkOutput("loclamp_done", 32'(ifc2.calib_done), 1);
        checkOutput("loclamp_state", 32'(ifc2.state), 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
